out_port_fifo: RTL

Output-port buffer directly downstream of the processor's OUT port register.
- Captures each 4-bit value the controller writes to the output port from Bus B.
- Queues the values and presents them to an external consumer over a valid/ready handshake.
- Lets the 4-bit core issue back-to-back OUT instructions without losing data to a slow peripheral.
- Also keeps a latched copy of the last value consumed, for LED/display use.

---
 rtl/out_port_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/out_port_fifo.sv
// out_port_fifo
//   Buffers the 4-bit values that the controller writes to the OUT port. The head entry is
//   presented to an external consumer over a valid/ready handshake (show-ahead). A copy of
//   the last value the consumer accepted is held for LED/display use.
//
//   Ports:
//     clk, rst       - clock; asynchronous active-high reset
//     wr_en, wr_data - write strobe and data from Bus B; one entry per cycle wr_en is high
//     full           - count == DEPTH; a write with no pop in the same cycle is dropped
//     out_data       - head entry; valid only while out_valid is high
//     out_valid      - FIFO not empty
//     out_ready      - consumer accepts out_data this cycle
//     out_latched    - last value transferred to the consumer
//     count          - occupancy, 0..DEPTH
//     ovf, ovf_clr   - sticky dropped-write flag and its clear (only with OUT_FIFO_OVF_EN)
//
//   Build option: define OUT_FIFO_OVF_EN to add the ovf/ovf_clr ports.
module out_port_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_latched,
`ifdef OUT_FIFO_OVF_EN
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  input  logic             ovf_clr
`else
  output logic [CNT_W-1:0] count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push = wr_en & (~full | pop);

  // Storage is not reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_latched <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        out_latched <= out_data;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef OUT_FIFO_OVF_EN
  logic drop;
  assign drop = wr_en & full & ~pop;

  // A drop in the same cycle as a clear wins, so no overflow goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
